// File: rtl/window_serializer.sv
// window_serializer: parallel-in / serial-out window streamer.
// Captures one flattened window of DEPTH words on a load handshake, then
// streams it oldest-first (word DEPTH-1 down to word 0) over valid/ready.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load_valid/ready    window load handshake
//   data_in_flat        word k at bits [(k+1)*WORD_WIDTH-1 : k*WORD_WIDTH]
//   dout/valid/ready    serial output stream
//   dout_last           high with word 0, the final beat of a window
//   busy                a window is being streamed
module window_serializer #(
    parameter int unsigned WORD_WIDTH = 4,
    parameter int unsigned DEPTH      = 21
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [WORD_WIDTH*DEPTH-1:0]   data_in_flat,
    output logic [WORD_WIDTH-1:0]         dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          dout_last,
    output logic                          busy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DEPTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_dec;
    logic [WORD_WIDTH-1:0] buffer [DEPTH];

    // Index of the word presented after the current beat completes.
    assign idx_dec = idx - IDX_W'(1);

    // Control FSM, window buffer and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
            for (int k = 0; k < int'(DEPTH); k++) begin
                buffer[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        for (int k = 0; k < int'(DEPTH); k++) begin
                            buffer[k] <= data_in_flat[k*WORD_WIDTH +: WORD_WIDTH];
                        end
                        // First word is taken straight from the input so it is
                        // presented on the cycle after the handshake.
                        dout       <= data_in_flat[(DEPTH-1)*WORD_WIDTH +: WORD_WIDTH];
                        idx        <= IDX_TOP;
                        dout_valid <= 1'b1;
                        dout_last  <= 1'b0;
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    // Without dout_ready everything holds: no skip, no repeat.
                    if (dout_ready) begin
                        if (idx != '0) begin
                            idx       <= idx_dec;
                            dout      <= buffer[idx_dec];
                            dout_last <= (idx_dec == '0);
                        end else begin
                            dout_valid <= 1'b0;
                            dout_last  <= 1'b0;
                            busy       <= 1'b0;
                            load_ready <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
